// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - 5-bit opcode encodings (also decoded by the control unit)
//   - divider FSM state encoding
//   - op_is_legal(): true for every opcode the ALU implements
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_SHRA = 5'b10101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROL, OP_AND, OP_OR,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_SHRA: op_is_legal = 1'b1;
      default:                                 op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_div_iter.sv
// div_iter: WIDTH-step restoring divider on unsigned magnitudes.
//   clk       rising-edge clock
//   clear     synchronous active-high reset, abandons a running division
//   start     one-cycle pulse: load operands and perform the first step
//   dividend  unsigned dividend magnitude
//   divisor   unsigned divisor magnitude (non-zero)
//   done      one-cycle pulse, high in the cycle whose edge performs the last step
//   quotient  unsigned quotient, valid after the edge that ends the done pulse
//   remainder unsigned remainder, valid alongside quotient
module div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;
  // The start edge performs step 1, so WIDTH-1 steps remain afterwards.
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor and keep the difference if non-negative.
  // The partial remainder is always below the divisor, so it fits WIDTH bits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] rs;
    logic [WIDTH:0] trial;
    rs    = {r, q[WIDTH-1]};
    trial = rs - {1'b0, d};
    if (trial[WIDTH]) div_step = {rs[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    else              div_step = {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (clear)            cnt <= '0;
    else if (start)       cnt <= CNT_LOAD;
    else if (cnt != '0)   cnt <= cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      {rem_q, quo_q} <= div_step('0, dividend, divisor);
      dvs_q          <= divisor;
    end else if (cnt != '0) begin
      {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
    end
  end

  assign done      = (cnt == CNT_ONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage handshaked ALU.
//   clk, clear                 clock and synchronous active-high reset
//   in_valid / in_ready        input handshake for A_reg, B_reg, opcode
//   A_reg, B_reg               operands (B alone for NEG/NOT, B[SHW-1:0] = shift)
//   opcode                     5-bit operation code (see alu_pkg)
//   out_valid / out_ready      output handshake for C_reg and flags
//   C_reg                      2*WIDTH result
//   zero, div_by_zero, illegal_op  flags of the presented result
// Stage 1 holds the accepted op; execute writes the output register when the
// op is complete and the output slot is free. Signed DIV uses div_iter and
// stalls stage 1 for WIDTH iterations plus one sign-fix cycle.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A_reg,
  input  logic [WIDTH-1:0]   B_reg,
  input  logic [4:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] C_reg,
  output logic               zero,
  output logic               div_by_zero,
  output logic               illegal_op
);

  logic                    vld_p1;
  logic [4:0]              op_p1;
  logic [WIDTH-1:0]        a_p1;
  logic [WIDTH-1:0]        b_p1;
  logic signed [WIDTH-1:0] a_s;
  logic [SHW-1:0]          sh;

  state_t           state;
  logic             slot_free;
  logic             is_div;
  logic             b_zero;
  logic             op_done;
  logic             exec_write;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  logic [2*WIDTH-1:0]      res;
  logic                    res_dbz;
  logic                    res_ill;
  logic [2*WIDTH-1:0]      rot_full;
  logic [2*WIDTH-1:0]      prod;
  logic signed [WIDTH-1:0] sra;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    mag = x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             neg);
    cond_neg = neg ? (~x + WIDTH'(1)) : x;
  endfunction

  assign a_s       = a_p1;
  assign sh        = b_p1[SHW-1:0];
  assign slot_free = !out_valid | out_ready;
  assign is_div    = (op_p1 == OP_DIV);
  assign b_zero    = (b_p1 == '0);
  // Everything but a real division completes in its first execute cycle.
  assign op_done    = !is_div | b_zero | (state == DIV_DONE);
  assign exec_write = vld_p1 & op_done & slot_free;
  assign in_ready   = !vld_p1 | (op_done & slot_free);
  assign div_start  = vld_p1 & is_div & !b_zero & (state == IDLE);

  // ---- stage 1: accepted operands and opcode ----
  always_ff @(posedge clk) begin
    if (clear)                     vld_p1 <= 1'b0;
    else if (in_valid & in_ready)  vld_p1 <= 1'b1;
    else if (exec_write)           vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_valid & in_ready) begin
      a_p1  <= A_reg;
      b_p1  <= B_reg;
      op_p1 <= opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (div_start) state <= DIV_RUN;
        DIV_RUN:  if (div_done)  state <= DIV_DONE;
        DIV_DONE: if (slot_free) state <= IDLE;
        default:                 state <= IDLE;
      endcase
    end
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .clear     (clear),
    .start     (div_start),
    .dividend  (mag(a_p1)),
    .divisor   (mag(b_p1)),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // ---- execute: combinational result for the op in stage 1 ----
  always_comb begin
    res      = '0;
    res_dbz  = 1'b0;
    res_ill  = !op_is_legal(op_p1);
    rot_full = {a_p1, a_p1} << sh;
    prod     = {{WIDTH{a_p1[WIDTH-1]}}, a_p1} * {{WIDTH{b_p1[WIDTH-1]}}, b_p1};
    sra      = a_s >>> sh;
    case (op_p1)
      OP_ADD:  res = {{WIDTH{1'b0}}, a_p1 + b_p1};
      OP_SUB:  res = {{WIDTH{1'b0}}, a_p1 - b_p1};
      OP_SHR:  res = {{WIDTH{1'b0}}, a_p1 >> sh};
      OP_SHL:  res = {{WIDTH{1'b0}}, a_p1 << sh};
      OP_ROL:  res = {{WIDTH{1'b0}}, rot_full[2*WIDTH-1:WIDTH]};
      OP_AND:  res = {{WIDTH{1'b0}}, a_p1 & b_p1};
      OP_OR:   res = {{WIDTH{1'b0}}, a_p1 | b_p1};
      OP_MUL:  res = prod;
      OP_NEG:  res = {{WIDTH{1'b0}}, ~b_p1 + WIDTH'(1)};
      OP_NOT:  res = {{WIDTH{1'b0}}, ~b_p1};
      OP_SHRA: res = {{WIDTH{1'b0}}, sra};
      OP_DIV: begin
        if (b_zero) begin
          res     = {a_p1, {WIDTH{1'b1}}};
          res_dbz = 1'b1;
        end else begin
          // Remainder follows the sign of A; quotient is negative when signs differ.
          res = {cond_neg(div_r, a_p1[WIDTH-1]),
                 cond_neg(div_q, a_p1[WIDTH-1] ^ b_p1[WIDTH-1])};
        end
      end
      default: res = '0;
    endcase
  end

  // ---- stage 2: output register ----
  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid   <= 1'b0;
      C_reg       <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (exec_write) begin
      out_valid   <= 1'b1;
      C_reg       <= res;
      zero        <= (res == '0);
      div_by_zero <= res_dbz;
      illegal_op  <= res_ill;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe (WIDTH=32 and WIDTH=16 builds).
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        zero, div_by_zero, illegal_op;
  logic [31:0] a_reg, b_reg;
  logic [4:0]  opcode;
  logic [63:0] c_reg;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic        zero16, dbz16, ill16;
  logic [15:0] a16, b16;
  logic [4:0]  op16;
  logic [31:0] c16;

  int tests_run = 0;
  int tests_failed = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .A_reg(a_reg), .B_reg(b_reg), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .C_reg(c_reg),
    .zero(zero), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .clear(clear), .in_valid(in_valid16), .in_ready(in_ready16),
    .A_reg(a16), .B_reg(b16), .opcode(op16),
    .out_valid(out_valid16), .out_ready(out_ready16), .C_reg(c16),
    .zero(zero16), .div_by_zero(dbz16), .illegal_op(ill16)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; opcode = op; a_reg = a; b_reg = b;
  endtask

  task automatic test_reset;
    clear = 1'b1;
    tick; tick;
    clear = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (c_reg !== 64'h0) begin tests_failed++; $display("FAIL reset_c_reg: got %h want 0", c_reg); end
    tests_run++; if ({zero, div_by_zero, illegal_op} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {zero, div_by_zero, illegal_op}); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests_run++; if ({out_valid16, in_ready16, c16} !== {2'b01, 32'h0}) begin tests_failed++; $display("FAIL reset_w16: got %b %b %h want 0 1 0", out_valid16, in_ready16, c16); end
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    drive(OP_ADD, 32'd5, 32'd7);
    tick;
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
    tick;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_valid: got %b want 1", out_valid); end
    tests_run++; if (c_reg !== 64'h0000_0000_0000_000C) begin tests_failed++; $display("FAIL add_c_reg: got %h want 000000000000000c", c_reg); end
    tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("FAIL add_zero: got %b want 0", zero); end
    tick;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL add_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stream;
    logic [4:0]  ops [12];
    logic [31:0] as  [12];
    logic [31:0] bs  [12];
    logic [63:0] exps[12];
    ops  = '{OP_SUB, OP_AND, OP_ROL, OP_SHRA, OP_SHR, OP_SHL, OP_OR, OP_NEG, OP_NOT, OP_MUL, OP_ADD, OP_MUL};
    as   = '{32'd3, 32'hF0F0_1234, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h1,
             32'h0F00_0000, 32'h1234, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    bs   = '{32'd5, 32'h0FF0_FF00, 32'd33, 32'd4, 32'd36, 32'd31,
             32'h0000_00F0, 32'd5, 32'h0, 32'd3, 32'd1, 32'h7FFF_FFFF};
    exps = '{64'h0000_0000_FFFF_FFFE, 64'h0000_0000_00F0_1200, 64'h0000_0000_0000_0003,
             64'h0000_0000_F800_0000, 64'h0000_0000_0800_0000, 64'h0000_0000_8000_0000,
             64'h0000_0000_0F00_00F0, 64'h0000_0000_FFFF_FFFB, 64'h0000_0000_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFA, 64'h0, 64'h3FFF_FFFF_0000_0001};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        drive(ops[i], as[i], bs[i]);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2) begin
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_valid[%0d]: got %b want 1", i-2, out_valid); end
        tests_run++; if (c_reg !== exps[i-2]) begin tests_failed++; $display("FAIL stream_c_reg[%0d]: got %h want %h", i-2, c_reg, exps[i-2]); end
        tests_run++; if (zero !== (exps[i-2] == 64'h0)) begin tests_failed++; $display("FAIL stream_zero[%0d]: got %b want %b", i-2, zero, exps[i-2] == 64'h0); end
      end
      tick;
    end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_div;
    logic [31:0] da[2];
    logic [31:0] db[2];
    logic [63:0] dexp[2];
    logic        bad_ready, bad_valid;
    da   = '{32'hFFFF_FF9C, 32'd100};
    db   = '{32'd7, 32'hFFFF_FFF9};
    dexp = '{{32'hFFFF_FFFE, 32'hFFFF_FFF2}, {32'h0000_0002, 32'hFFFF_FFF2}};
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(OP_DIV, da[k], db[k]);
      tick;
      in_valid = 1'b0;
      bad_ready = (in_ready !== 1'b0);
      bad_valid = (out_valid !== 1'b0);
      for (int e = 1; e <= 32; e++) begin
        tick;
        if (e <= 31 && in_ready !== 1'b0) bad_ready = 1'b1;
        if (out_valid !== 1'b0) bad_valid = 1'b1;
      end
      tests_run++; if (bad_ready) begin tests_failed++; $display("FAIL div_in_ready_low[%0d]: got high want low during run", k); end
      tests_run++; if (bad_valid) begin tests_failed++; $display("FAIL div_early_valid[%0d]: got high want low before edge 33", k); end
      tick;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL div_valid[%0d]: got %b want 1", k, out_valid); end
      tests_run++; if (c_reg !== dexp[k]) begin tests_failed++; $display("FAIL div_c_reg[%0d]: got %h want %h", k, c_reg, dexp[k]); end
      tests_run++; if ({div_by_zero, illegal_op} !== 2'b00) begin tests_failed++; $display("FAIL div_flags[%0d]: got %b want 00", k, {div_by_zero, illegal_op}); end
      tick;
    end
  endtask

  task automatic test_div_zero;
    out_ready = 1'b1;
    drive(OP_DIV, 32'd9, 32'd0);
    tick;
    in_valid = 1'b0;
    tick;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL divz_valid: got %b want 1", out_valid); end
    tests_run++; if (c_reg !== 64'h0000_0009_FFFF_FFFF) begin tests_failed++; $display("FAIL divz_c_reg: got %h want 00000009ffffffff", c_reg); end
    tests_run++; if ({zero, div_by_zero, illegal_op} !== 3'b010) begin tests_failed++; $display("FAIL divz_flags: got %b want 010", {zero, div_by_zero, illegal_op}); end
    drive(5'b11111, 32'h1234_5678, 32'h9ABC_DEF0);
    tick;
    in_valid = 1'b0;
    tick;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ill_valid: got %b want 1", out_valid); end
    tests_run++; if (c_reg !== 64'h0) begin tests_failed++; $display("FAIL ill_c_reg: got %h want 0", c_reg); end
    tests_run++; if ({zero, div_by_zero, illegal_op} !== 3'b101) begin tests_failed++; $display("FAIL ill_flags: got %b want 101", {zero, div_by_zero, illegal_op}); end
    tick;
  endtask

  task automatic test_stall;
    logic bad;
    out_ready = 1'b0;
    drive(OP_ADD, 32'd1, 32'd2);
    tick;
    drive(OP_SUB, 32'd10, 32'd4);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_second_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1 || c_reg !== 64'd3 || in_ready !== 1'b0) bad = 1'b1;
      tick;
    end
    tests_run++; if (bad) begin tests_failed++; $display("FAIL stall_hold: got c_reg %h valid %b ready %b want 3 1 0", c_reg, out_valid, in_ready); end
    out_ready = 1'b1;
    tick;
    tests_run++; if (out_valid !== 1'b1 || c_reg !== 64'd6) begin tests_failed++; $display("FAIL stall_second_out: got %b %h want 1 6", out_valid, c_reg); end
    tick;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_clear_mid_div;
    logic bad;
    out_ready = 1'b1;
    drive(OP_DIV, 32'd1000, 32'd3);
    tick;
    in_valid = 1'b0;
    repeat (10) tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    tests_run++; if ({out_valid, zero, div_by_zero, illegal_op} !== 4'b0000 || c_reg !== 64'h0) begin tests_failed++; $display("FAIL clr_outputs: got %b %h want 0000 0", {out_valid, zero, div_by_zero, illegal_op}, c_reg); end
    tests_run++; if (dut.state !== IDLE) begin tests_failed++; $display("FAIL clr_state: got %0d want %0d", dut.state, IDLE); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL clr_in_ready: got %b want 1", in_ready); end
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      tick;
    end
    tests_run++; if (bad) begin tests_failed++; $display("FAIL clr_stray_result: got out_valid high want low"); end
    drive(OP_ADD, 32'd1, 32'd1);
    tick;
    in_valid = 1'b0;
    tick;
    tests_run++; if (out_valid !== 1'b1 || c_reg !== 64'd2) begin tests_failed++; $display("FAIL clr_add: got %b %h want 1 2", out_valid, c_reg); end
    tick;
  endtask

  task automatic test_w16;
    out_ready16 = 1'b1;
    in_valid16 = 1'b1; op16 = OP_MUL; a16 = 16'hFFFE; b16 = 16'd3;
    tick;
    in_valid16 = 1'b0;
    tick;
    tests_run++; if (out_valid16 !== 1'b1 || c16 !== 32'hFFFF_FFFA) begin tests_failed++; $display("FAIL w16_mul: got %b %h want 1 fffffffa", out_valid16, c16); end
    tick;
    in_valid16 = 1'b1; op16 = OP_DIV; a16 = 16'h8000; b16 = 16'hFFFF;
    tick;
    in_valid16 = 1'b0;
    tests_run++; if (in_ready16 !== 1'b0) begin tests_failed++; $display("FAIL w16_div_ready: got %b want 0", in_ready16); end
    repeat (16) tick;
    tests_run++; if (out_valid16 !== 1'b0) begin tests_failed++; $display("FAIL w16_div_early: got %b want 0", out_valid16); end
    tick;
    tests_run++; if (out_valid16 !== 1'b1 || c16 !== 32'h0000_8000) begin tests_failed++; $display("FAIL w16_div: got %b %h want 1 00008000", out_valid16, c16); end
    tests_run++; if ({zero16, dbz16, ill16} !== 3'b000) begin tests_failed++; $display("FAIL w16_div_flags: got %b want 000", {zero16, dbz16, ill16}); end
    tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_reg = '0; b_reg = '0; opcode = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; op16 = '0;
    #1;
    test_reset;
    test_add;
    test_stream;
    test_div;
    test_div_zero;
    test_stall;
    test_clear_mid_div;
    test_w16;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
